// File: rtl/ft245_cmd_parser.sv
// Receive-side frame parser for the FT245 byte stream: finds SYNC,CMD,LEN,payload,CHK
// frames, streams the payload out and reports per-frame status and a bad-frame count.
module ft245_cmd_parser #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_LEN   = 64,
  parameter int         TIMEOUT   = 1000000,
  parameter int         CNT_W     = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [7:0]       RxData,
  input  logic             RxValid,
  output logic             Busy,
  output logic [7:0]       Cmd,
  output logic [7:0]       Len,
  output logic [7:0]       PayData,
  output logic             PayValid,
  output logic [7:0]       PayIndex,
  output logic             FrameDone,
  output logic             FrameOK,
  output logic [1:0]       ErrCode,
  output logic [CNT_W-1:0] ErrCount
);

  typedef enum logic [2:0] {HUNT, CMD, LEN, PAYLOAD, CHECK} state_t;

  localparam int         TW        = $clog2(TIMEOUT + 1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t          state;
  logic [7:0]      chk;
  logic [7:0]      idx;
  logic [TW-1:0]   tcnt;
  logic [CNT_W-1:0] err_count_inc;

  assign Busy          = (state != HUNT);
  assign err_count_inc = (&ErrCount) ? ErrCount : ErrCount + 1'b1;

  // NOTE: all state here is sequential, so every assignment is non-blocking; the
  // reset branch clears every register, including the error counter.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= HUNT;
      chk       <= '0;
      idx       <= '0;
      tcnt      <= '0;
      Cmd       <= '0;
      Len       <= '0;
      PayData   <= '0;
      PayValid  <= 1'b0;
      PayIndex  <= '0;
      FrameDone <= 1'b0;
      FrameOK   <= 1'b0;
      ErrCode   <= '0;
      ErrCount  <= '0;
    end else begin
      PayValid  <= 1'b0;
      FrameDone <= 1'b0;

      if (state == HUNT) begin
        tcnt <= '0;
        if (RxValid && RxData == SYNC_BYTE) state <= CMD;
      end else if (!RxValid) begin
        // A byte arriving on the expiry cycle wins over the timeout.
        if (tcnt == TW'(TIMEOUT - 1)) begin
          tcnt      <= '0;
          state     <= HUNT;
          FrameDone <= 1'b1;
          FrameOK   <= 1'b0;
          ErrCode   <= 2'd3;
          ErrCount  <= err_count_inc;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end else begin
        tcnt <= '0;
        case (state)
          CMD: begin
            Cmd   <= RxData;
            chk   <= RxData;
            state <= LEN;
          end
          LEN: begin
            Len <= RxData;
            chk <= chk ^ RxData;
            idx <= '0;
            if (RxData > MAX_LEN_B) begin
              state     <= HUNT;
              FrameDone <= 1'b1;
              FrameOK   <= 1'b0;
              ErrCode   <= 2'd2;
              ErrCount  <= err_count_inc;
            end else if (RxData == 8'd0) begin
              state <= CHECK;
            end else begin
              state <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            PayData  <= RxData;
            PayValid <= 1'b1;
            PayIndex <= idx;
            chk      <= chk ^ RxData;
            idx      <= idx + 8'd1;
            if (idx + 8'd1 == Len) state <= CHECK;
          end
          CHECK: begin
            state     <= HUNT;
            FrameDone <= 1'b1;
            FrameOK   <= (RxData == chk);
            if (RxData == chk) begin
              ErrCode <= 2'd0;
            end else begin
              ErrCode  <= 2'd1;
              ErrCount <= err_count_inc;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ft245_cmd_parser.sv
// Directed bench for ft245_cmd_parser with MAX_LEN=64 and TIMEOUT=16; bytes are driven
// just after a rising edge and outputs sampled 1 time unit after the edge that took them.
module tb_ft245_cmd_parser;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [7:0]  RxData = 8'h00;
  logic        RxValid = 1'b0;
  logic        Busy;
  logic [7:0]  Cmd;
  logic [7:0]  Len;
  logic [7:0]  PayData;
  logic        PayValid;
  logic [7:0]  PayIndex;
  logic        FrameDone;
  logic        FrameOK;
  logic [1:0]  ErrCode;
  logic [15:0] ErrCount;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_cnt = 16'd0;

  ft245_cmd_parser #(
    .SYNC_BYTE(8'hA5),
    .MAX_LEN  (64),
    .TIMEOUT  (16),
    .CNT_W    (16)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .RxData   (RxData),
    .RxValid  (RxValid),
    .Busy     (Busy),
    .Cmd      (Cmd),
    .Len      (Len),
    .PayData  (PayData),
    .PayValid (PayValid),
    .PayIndex (PayIndex),
    .FrameDone(FrameDone),
    .FrameOK  (FrameOK),
    .ErrCode  (ErrCode),
    .ErrCount (ErrCount)
  );

  always #5 Clock = ~Clock;

  task automatic send(input logic [7:0] b);
    RxData  = b;
    RxValid = 1'b1;
    @(posedge Clock);
    #1;
    RxValid = 1'b0;
  endtask

  task automatic idle(input int n);
    RxValid = 1'b0;
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic expect_no_strobe(input string name);
    checks++;
    if ({PayValid, FrameDone} !== 2'b00) begin
      errors++;
      $display("FAIL %s: PayValid/FrameDone got %b want 00", name, {PayValid, FrameDone});
    end
  endtask

  task automatic expect_pay(input string name, input logic [7:0] d, input logic [7:0] i);
    checks++;
    if ({PayValid, PayData, PayIndex, FrameDone} !== {1'b1, d, i, 1'b0}) begin
      errors++;
      $display("FAIL %s: valid/data/idx/done got %b/%h/%0d/%b want 1/%h/%0d/0",
               name, PayValid, PayData, PayIndex, FrameDone, d, i);
    end
  endtask

  task automatic expect_done(input string name, input logic ok, input logic [1:0] code);
    checks++;
    if ({FrameDone, FrameOK, ErrCode, ErrCount, Busy, PayValid} !==
        {1'b1, ok, code, exp_cnt, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s: done/ok/code/cnt/busy/pv got %b/%b/%0d/%0d/%b/%b want 1/%b/%0d/%0d/0/0",
               name, FrameDone, FrameOK, ErrCode, ErrCount, Busy, PayValid, ok, code, exp_cnt);
    end
  endtask

  task automatic expect_hdr(input string name, input logic [7:0] c, input logic [7:0] l);
    checks++;
    if ({Cmd, Len} !== {c, l}) begin
      errors++;
      $display("FAIL %s: Cmd/Len got %h/%h want %h/%h", name, Cmd, Len, c, l);
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    idle(2);
    Reset = 1'b0;
    checks++;
    if ({Busy, Cmd, Len, PayData, PayValid, PayIndex, FrameDone, FrameOK, ErrCode, ErrCount} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b cmd=%h len=%h pd=%h pv=%b pi=%h fd=%b ok=%b code=%0d cnt=%0d want all 0",
               Busy, Cmd, Len, PayData, PayValid, PayIndex, FrameDone, FrameOK, ErrCode, ErrCount);
    end
    exp_cnt = 16'd0;
  endtask

  task automatic test_good_frame;
    send(8'hA5);
    checks++;
    if (Busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_sync: got %b want 1", Busy);
    end
    send(8'h01); expect_no_strobe("good_cmd");
    send(8'h02); expect_no_strobe("good_len");
    send(8'h11); expect_pay("good_pay0", 8'h11, 8'd0);
    send(8'h22); expect_pay("good_pay1", 8'h22, 8'd1);
    send(8'h30); expect_done("good_done", 1'b1, 2'd0);
    expect_hdr("good_hdr", 8'h01, 8'h02);
  endtask

  task automatic test_bad_checksum;
    send(8'hA5); send(8'h01); send(8'h02); send(8'h11); send(8'h22);
    exp_cnt = exp_cnt + 16'd1;
    send(8'h31); expect_done("bad_chk_done", 1'b0, 2'd1);
    idle(3);
    checks++;
    if ({FrameDone, ErrCode, ErrCount} !== {1'b0, 2'd1, exp_cnt}) begin
      errors++;
      $display("FAIL bad_chk_hold: done/code/cnt got %b/%0d/%0d want 0/1/%0d",
               FrameDone, ErrCode, ErrCount, exp_cnt);
    end
  endtask

  task automatic test_zero_len;
    send(8'hA5); send(8'h07);
    send(8'h00); expect_no_strobe("zero_len_len");
    send(8'h07); expect_done("zero_len_done", 1'b1, 2'd0);
    expect_hdr("zero_len_hdr", 8'h07, 8'h00);
  endtask

  task automatic test_length_error;
    send(8'hA5); send(8'h01);
    send(8'h40); idle(1);
    expect_no_strobe("len64_midframe");
    checks++;
    if (Busy !== 1'b1) begin
      errors++;
      $display("FAIL len64_busy: got %b want 1", Busy);
    end
    Reset = 1'b1; idle(1); Reset = 1'b0;
    exp_cnt = 16'd0;
    send(8'hA5); send(8'h01);
    exp_cnt = exp_cnt + 16'd1;
    send(8'h41); expect_done("len_err_done", 1'b0, 2'd2);
    expect_hdr("len_err_hdr", 8'h01, 8'h41);
    send(8'hA5); send(8'h01); send(8'h01);
    send(8'h55); expect_pay("after_len_pay", 8'h55, 8'd0);
    send(8'h55); expect_done("after_len_done", 1'b1, 2'd0);
  endtask

  task automatic test_timeout;
    send(8'hA5); send(8'h01);
    idle(15); expect_no_strobe("timeout_15_idle");
    exp_cnt = exp_cnt + 16'd1;
    idle(1); expect_done("timeout_done", 1'b0, 2'd3);
    send(8'hA5); send(8'h01);
    idle(15);
    send(8'h00); expect_no_strobe("timeout_saved");
    checks++;
    if (Busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_saved_busy: got %b want 1", Busy);
    end
    send(8'h01); expect_done("timeout_saved_done", 1'b1, 2'd0);
  endtask

  task automatic test_junk_and_sync_payload;
    send(8'h00); expect_no_strobe("junk_00");
    send(8'hFF);
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL junk_busy: got %b want 0", Busy);
    end
    send(8'hA5); send(8'hA5); send(8'h01);
    send(8'hA5); expect_pay("sync_as_data", 8'hA5, 8'd0);
    send(8'h01); expect_done("sync_payload_done", 1'b1, 2'd0);
    expect_hdr("sync_payload_hdr", 8'hA5, 8'h01);
  endtask

  task automatic test_back_to_back;
    send(8'hA5); send(8'h02); send(8'h00);
    send(8'h02); expect_done("b2b_first", 1'b1, 2'd0);
    send(8'hA5); send(8'h03); send(8'h01);
    send(8'h44); expect_pay("b2b_pay", 8'h44, 8'd0);
    send(8'h46); expect_done("b2b_second", 1'b1, 2'd0);
    expect_hdr("b2b_hdr", 8'h03, 8'h01);
  endtask

  task automatic test_reset_mid_frame;
    send(8'hA5); send(8'h09); send(8'h03);
    send(8'h11); expect_pay("mid_pay", 8'h11, 8'd0);
    Reset = 1'b1;
    idle(1);
    checks++;
    if ({Busy, Cmd, Len, PayData, PayValid, PayIndex, FrameDone, FrameOK, ErrCode, ErrCount} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got busy=%b cmd=%h len=%h pd=%h pv=%b pi=%h fd=%b ok=%b code=%0d cnt=%0d want all 0",
               Busy, Cmd, Len, PayData, PayValid, PayIndex, FrameDone, FrameOK, ErrCode, ErrCount);
    end
    Reset = 1'b0;
    exp_cnt = 16'd0;
    idle(1); expect_no_strobe("mid_reset_quiet");
    send(8'hA5); send(8'h01); send(8'h02);
    send(8'h11); expect_pay("post_reset_pay0", 8'h11, 8'd0);
    send(8'h22); expect_pay("post_reset_pay1", 8'h22, 8'd1);
    send(8'h30); expect_done("post_reset_done", 1'b1, 2'd0);
  endtask

  initial begin
    test_reset;
    test_good_frame;
    test_bad_checksum;
    test_zero_len;
    test_length_error;
    test_timeout;
    test_junk_and_sync_payload;
    test_back_to_back;
    test_reset_mid_frame;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
